// File: rtl/dv_mem_master.sv
// Burst initiator for a single-port synchronous memory: turns write/read burst commands
// into per-word memory cycles, with a 2-entry buffer absorbing the 1-cycle read latency.
module dv_mem_master #(
  parameter int DW = 16,
  parameter int AW = 20,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  // All handshakes: a beat transfers on a rising edge where valid && ready are both
  // high; a source holds valid and its payload stable until that edge.

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [LW-1:0] cnt;
  logic          inflight;
  logic [1:0]    buf_cnt;
  logic [DW-1:0] buf0;
  logic [DW-1:0] buf1;

  logic pop;
  logic push;
  logic issue;

  assign pop  = rd_valid && rd_ready;
  assign push = inflight;

  // Issue only if the word can land without overflowing, counting this cycle's pop.
  assign issue = (state == READ) &&
                 (({1'b0, buf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);
  assign mem_we    = (state == WRITE) && wr_valid;
  assign mem_addr  = addr;
  assign mem_din   = wr_data;
  assign rd_valid  = (buf_cnt != 2'd0);
  assign rd_data   = buf0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= issue;

      // buf0 is always the head; simultaneous push and pop keeps the count and order.
      unique case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= mem_dout;
          else                 buf1 <= mem_dout;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= mem_dout;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_dout;
          end
        end
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr  <= cmd_addr;
            cnt   <= cmd_len;
            state <= cmd_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            addr <= addr + AW'(1);
            cnt  <= cnt - LW'(1);
            if (cnt == '0) state <= IDLE;
          end
        end
        READ: begin
          if (issue) begin
            addr <= addr + AW'(1);
            cnt  <= cnt - LW'(1);
            if (cnt == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight && (buf_cnt == {1'b0, pop})) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (buf_cnt == 2'd2)));

endmodule

// File: tb/tb_dv_mem_master.sv
// Self-checking bench for dv_mem_master: synchronous memory model, reference memory
// image, and a scoreboard of expected memory writes and read beats.
module tb_dv_mem_master;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int LW = 8;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dv_mem_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // ---------------- memory model (environment) ----------------
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  logic [DW-1:0] mem [0:MSIZE-1];
  initial for (int i = 0; i < MSIZE; i++) mem[i] = dflt(AW'(i));

  always @(posedge clk) begin
    mem_dout <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0]    ref_mem [logic [AW-1:0]];
  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] wexp_q[$];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input int i);
    return AW'((int'(base) + i) % MSIZE);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // ---------------- monitor ----------------
  int               we_cnt = 0;
  int               pop_cnt = 0;
  logic             stall_q = 1'b0;
  logic [DW-1:0]    stall_data;
  logic [AW+DW-1:0] we_exp;
  logic [DW-1:0]    rd_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        we_cnt++;
        if (wexp_q.size() == 0) fail_now("unexpected_mem_write");
        else begin
          we_exp = wexp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(we_exp[AW+DW-1:DW]));
          check("wr_data", 32'(mem_din), 32'(we_exp[DW-1:0]));
        end
      end
      if (cmd_valid) check("cmd_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      if (stall_q) begin
        check("rd_hold_valid", 32'(rd_valid), 32'd1);
        check("rd_hold_data", 32'(rd_data), 32'(stall_data));
      end
      if (rd_valid && rd_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) fail_now("unexpected_rd_beat");
        else begin
          rd_exp = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(rd_exp));
        end
      end
      stall_q    = rd_valid && !rd_ready;
      stall_data = rd_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  // ---------------- rd_ready driver ----------------
  int rd_mode = 0;
  int rd_phase = 0;
  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0:       rd_ready = 1'b1;
      1:       begin rd_ready = ((rd_phase % 3) == 0); rd_phase++; end
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len);
    bit ok = 1'b0;
    cmd_wr = wr; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("cmd_accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [DW-1:0] d[$], input int gap_mode, output int cycles);
    int i = 0;
    bit ph = 1'b1;
    cycles = 0;
    while (i < d.size() && cycles < 2000) begin
      wr_data = d[i];
      case (gap_mode)
        0:       wr_valid = 1'b1;
        1:       begin wr_valid = ph; ph = !ph; end
        default: wr_valid = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      @(posedge clk); #1;
      cycles++;
    end
    wr_valid = 1'b0;
    if (i < d.size()) fail_now("wr_beat_timeout");
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int len, input int gap_mode,
                          input bit seq, input logic [DW-1:0] base, output int cycles);
    logic [DW-1:0] d[$];
    logic [DW-1:0] v;
    logic [AW-1:0] wa;
    for (int i = 0; i <= len; i++) begin
      v  = seq ? base + DW'(i) : DW'($urandom);
      wa = word_addr(a, i);
      d.push_back(v);
      ref_mem[wa] = v;
      wexp_q.push_back({wa, v});
    end
    send_cmd(1'b1, a, LW'(len));
    send_beats(d, gap_mode, cycles);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_rd(word_addr(a, i)));
    send_cmd(1'b0, a, LW'(len));
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && wexp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now({name, "_done_timeout"});
      exp_q.delete();
      wexp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int cyc_w, k, we0, p0;
    bit seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Gap-free write of A000..A003 at 0x10
    we0 = we_cnt;
    do_write(20'h00010, 3, 0, 1'b1, 16'hA000, cyc_w);
    check("t1_write_cycles", 32'(cyc_w), 32'd4);
    check("t1_we_count", 32'(we_cnt - we0), 32'd4);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_cmd_ready_after", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Read back with rd_ready high: latency and gap-free stream
    do_read(20'h00010, 3);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      seen = rd_valid;
    end
    check("t2_first_rd_latency", 32'(k - 1), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_rd_gapfree", 32'(rd_valid), 32'd1);
    end
    @(posedge clk); #1;
    wait_done("t2");

    // Same read under 1,0,0 backpressure
    rd_mode = 1; rd_phase = 0;
    do_read(20'h00010, 3);
    wait_done("t3");
    rd_mode = 0;

    // Address wrap at the top of memory
    do_write(20'hFFFFE, 3, 0, 1'b0, '0, cyc_w);
    do_read(20'hFFFFE, 3);
    wait_done("t4");
    check("t4_wrap_low", 32'(mem[0]), 32'(ref_rd(20'h00000)));

    // Gapped write with a read command queued while busy
    we0 = we_cnt;
    fork
      do_write(20'h00200, 1, 1, 1'b0, '0, cyc_w);
      begin
        k = 0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #2;
        do_read(20'h00200, 1);
      end
    join
    wait_done("t5");
    check("t5_we_pulses", 32'(we_cnt - we0), 32'd2);

    // Reset in the middle of a read burst
    p0 = pop_cnt;
    do_read(20'h00010, 7);
    k = 0;
    while ((pop_cnt - p0) < 2 && k < 40) begin @(negedge clk); k++; end
    check("t6_two_beats_seen", 32'(pop_cnt - p0), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(20'h00012, 0);
    wait_done("t6");

    // Randomized bursts, random backpressure and write gaps
    rd_mode = 2;
    for (int n = 0; n < 24; n++) begin
      logic [AW-1:0] a;
      int len;
      a   = ($urandom_range(0, 3) == 0) ? AW'(MSIZE - 1 - $urandom_range(0, 8))
                                        : AW'($urandom_range(0, MSIZE - 1));
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, len, 2, 1'b0, '0, cyc_w);
        do_read(a, len);
      end else begin
        do_read(a, len);
      end
      wait_done("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
